// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Package     : matmul_pkg
// Description : Shared defaults, width helpers and the row-result payload
//               type for the streaming matrix-multiplier row reducer.
// Contents    : DEF_DATA_W / DEF_DIM / DEF_ROWS defaults,
//               calc_sum_w() / calc_idx_w() width helpers,
//               row_result_t {sum, index, last} FIFO payload.
// Revision    : 1.0 - initial release
// ============================================================================
package matmul_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DIM    = 16;
    localparam int DEF_ROWS   = 16;

    // A row of DIM values of data_w bits each needs clog2(DIM) extra bits
    // so the total can never wrap.
    function automatic int calc_sum_w(input int data_w, input int dim);
        return data_w + $clog2(dim);
    endfunction

    // Row index width; never narrower than one bit.
    function automatic int calc_idx_w(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    localparam int DEF_SUM_W = calc_sum_w(DEF_DATA_W, DEF_DIM);
    localparam int DEF_IDX_W = calc_idx_w(DEF_ROWS);

    typedef struct packed {
        logic [DEF_SUM_W-1:0] sum;
        logic [DEF_IDX_W-1:0] index;
        logic                 last;
    } row_result_t;

endpackage
`default_nettype wire

// File: rtl/matmul_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : matmul_row_fifo
// Description : First-word-fall-through FIFO, parameterised on depth and
//               payload type. The head entry is visible on data_out whenever
//               the FIFO is not empty.
// Ports       : clock, reset (async, active-high)
//               push, data_in   - write side (push while full is accepted
//                                 only together with a pop)
//               pop, data_out   - read side (pop on empty is ignored)
//               full, empty, count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_row_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  T                         data_in,
    input  logic                     pop,
    output T                         data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    T                mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; consumers only look at it while not empty.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule
`default_nettype wire

// File: rtl/matmul_row_reducer.sv
`default_nettype none
// ============================================================================
// Module      : matmul_row_reducer
// Description : Sums every DIM consecutive result elements of the matrix
//               multiplier into a row total and emits {sum, index, last}
//               through a small FWFT FIFO. One element per cycle while the
//               output side keeps up.
// Ports       : clock, reset            - clock / async active-high reset
//               io_value_in_valid/ready/bits - element input stream
//               io_row_out_valid/ready   - row output handshake
//               io_row_out_sum/index/last - row total, row number, last row
//               io_err                   - sticky odd-element flag
// Options     : MATMUL_ROW_REDUCER_PARITY_CHECK_EN - when defined, io_err is
//               set after any accepted odd element and held until reset;
//               when undefined io_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_row_reducer
    import matmul_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DIM        = DEF_DIM,
    parameter int ROWS       = DEF_ROWS,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              io_value_in_valid,
    output logic                              io_value_in_ready,
    input  logic [DATA_W-1:0]                 io_value_in_bits,
    output logic                              io_row_out_valid,
    input  logic                              io_row_out_ready,
    output logic [calc_sum_w(DATA_W,DIM)-1:0] io_row_out_sum,
    output logic [calc_idx_w(ROWS)-1:0]       io_row_out_index,
    output logic                              io_row_out_last,
    output logic                              io_err
);

    localparam int SUM_W = calc_sum_w(DATA_W, DIM);
    localparam int IDX_W = calc_idx_w(ROWS);
    localparam int CNT_W = $clog2(DIM);
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    // Same layout as row_result_t, but sized from this instance's parameters.
    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [IDX_W-1:0] index;
        logic             last;
    } row_t;

    logic [CNT_W-1:0] elem_cnt;
    logic [SUM_W-1:0] acc;
    logic [IDX_W-1:0] row_idx;

    logic             last_elem;
    logic             row_last;
    logic [SUM_W-1:0] row_sum;
    logic             accept;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_count;
    row_t             push_data;
    row_t             head_data;
    logic             head_occupied;

    assign last_elem = (elem_cnt == CNT_W'(DIM - 1));
    assign row_last  = (row_idx == IDX_W'(ROWS - 1));
    assign row_sum   = acc + {{(SUM_W-DATA_W){1'b0}}, io_value_in_bits};

    assign fifo_pop  = !fifo_empty && io_row_out_ready;
    // Only the element that completes a row needs FIFO space; the pop term
    // lets a full FIFO keep streaming when downstream drains it.
    assign io_value_in_ready = !last_elem || !fifo_full || fifo_pop;
    assign accept    = io_value_in_valid && io_value_in_ready;
    assign fifo_push = accept && last_elem;

    assign push_data.sum   = row_sum;
    assign push_data.index = row_idx;
    assign push_data.last  = row_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            elem_cnt <= '0;
            acc      <= '0;
            row_idx  <= '0;
        end else if (accept) begin
            if (last_elem) begin
                elem_cnt <= '0;
                acc      <= '0;
                row_idx  <= row_last ? '0 : row_idx + IDX_W'(1);
            end else begin
                elem_cnt <= elem_cnt + CNT_W'(1);
                acc      <= row_sum;
            end
        end
    end

    matmul_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (row_t)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .data_in  (push_data),
        .pop      (fifo_pop),
        .data_out (head_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Payload is forced to zero while the FIFO holds nothing, so the
    // uninitialised storage never leaks onto the outputs.
    assign head_occupied    = (fifo_count != '0);
    assign io_row_out_valid = !fifo_empty;
    assign io_row_out_sum   = head_occupied ? head_data.sum   : '0;
    assign io_row_out_index = head_occupied ? head_data.index : '0;
    assign io_row_out_last  = head_occupied && head_data.last;

`ifdef MATMUL_ROW_REDUCER_PARITY_CHECK_EN
    // Results must be even; any accepted odd element latches the flag.
    logic err_flag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (accept && io_value_in_bits[0]) begin
            err_flag <= 1'b1;
        end
    end

    assign io_err = err_flag;
`else
    assign io_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_row_reducer.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul_row_reducer
// Description : Self-checking bench for matmul_row_reducer: table vectors,
//               hand-written backpressure / reset / parity sequences and a
//               randomized valid/ready run against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_row_reducer;

    localparam int DATA_W     = 32;
    localparam int DIM        = 16;
    localparam int ROWS       = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int SUM_W      = 36;
    localparam int IDX_W      = 4;
`ifdef MATMUL_ROW_REDUCER_PARITY_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_bits;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              err;

    matmul_row_reducer #(
        .DATA_W (DATA_W), .DIM (DIM), .ROWS (ROWS), .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_value_in_valid (in_valid),
        .io_value_in_ready (in_ready),
        .io_value_in_bits  (in_bits),
        .io_row_out_valid  (out_valid),
        .io_row_out_ready  (out_ready),
        .io_row_out_sum    (out_sum),
        .io_row_out_index  (out_index),
        .io_row_out_last   (out_last),
        .io_err            (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [IDX_W-1:0] index;
        logic             last;
    } row_rec_t;

    // Reference model state: elements of the current row, rows produced but
    // not yet taken downstream, rows taken downstream.
    logic [DATA_W-1:0] cur_q [$];
    row_rec_t          exp_q [$];
    row_rec_t          got_q [$];
    int                m_row;
    logic              m_err;

    int  cmp_cnt = 0;
    int  err_cnt = 0;
    bit  accepted_now;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        cur_q.delete();
        exp_q.delete();
        got_q.delete();
        m_row = 0;
        m_err = 1'b0;
    endtask

    // One clock cycle: drive, check at the falling edge, update the model
    // with the handshakes that will complete on the next rising edge.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
        logic     exp_valid;
        logic     exp_ready;
        logic [SUM_W-1:0] s;
        row_rec_t rec;
        in_valid  = v;
        in_bits   = d;
        out_ready = r;
        @(negedge clock);
        exp_valid = (exp_q.size() != 0);
        exp_ready = (cur_q.size() != DIM - 1) || (exp_q.size() < FIFO_DEPTH) || (exp_valid && r);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("in_ready",  64'(in_ready),  64'(exp_ready));
        chk("err",       64'(err),       64'(m_err));
        if (exp_valid && r) begin
            chk("row_sum",   64'(out_sum),   64'(exp_q[0].sum));
            chk("row_index", 64'(out_index), 64'(exp_q[0].index));
            chk("row_last",  64'(out_last),  64'(exp_q[0].last));
            rec.sum = out_sum; rec.index = out_index; rec.last = out_last;
            got_q.push_back(rec);
            void'(exp_q.pop_front());
        end
        accepted_now = v && exp_ready;
        if (accepted_now) begin
            if (PAR && d[0]) m_err = 1'b1;
            cur_q.push_back(d);
            if (cur_q.size() == DIM) begin
                s = '0;
                foreach (cur_q[i]) s = s + SUM_W'(cur_q[i]);
                rec.sum = s; rec.index = IDX_W'(m_row); rec.last = (m_row == ROWS - 1);
                exp_q.push_back(rec);
                m_row = (m_row + 1) % ROWS;
                cur_q.delete();
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic feed_elem(input logic [DATA_W-1:0] d, input logic r);
        int n = 0;
        do begin
            step(1'b1, d, r);
            n++;
        end while (!accepted_now && n < 200);
        if (!accepted_now) chk("feed_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Asynchronous assertion partway through a cycle; outputs must clear
    // without waiting for a clock edge. Release is synchronous to the bench.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_sum",       64'(out_sum),   64'd0);
        chk("rst_index",     64'(out_index), 64'd0);
        chk("rst_last",      64'(out_last),  64'd0);
        chk("rst_err",       64'(err),       64'd0);
        model_clear();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [DATA_W-1:0] val;
        logic [SUM_W-1:0]  exp_sum;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int   k;
        int   n;
        logic v;
        logic [DATA_W-1:0] d;

        vecs[0] = '{val: 32'd2,          exp_sum: 36'd32};
        vecs[1] = '{val: 32'hFFFF_FFFF,  exp_sum: 36'hF_FFFF_FFF0};
        vecs[2] = '{val: 32'd0,          exp_sum: 36'd0};
        vecs[3] = '{val: 32'h1234_5678,  exp_sum: 36'h1_2345_6780};

        in_valid  = 1'b0;
        in_bits   = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #2;
        do_reset();

        // Table: one row of a constant value, always ready.
        foreach (vecs[i]) begin
            do_reset();
            for (int j = 0; j < DIM; j++) feed_elem(vecs[i].val, 1'b1);
            drain();
            chk("tbl_rows",  64'(got_q.size()), 64'd1);
            if (got_q.size() >= 1) begin
                chk("tbl_sum",   64'(got_q[0].sum),   64'(vecs[i].exp_sum));
                chk("tbl_index", 64'(got_q[0].index), 64'd0);
            end
        end

        // Streaming 0,2,4,... for a full matrix.
        do_reset();
        for (int j = 0; j < DIM * ROWS; j++) feed_elem(DATA_W'(2 * j), 1'b1);
        drain();
        chk("stream_rows", 64'(got_q.size()), 64'(ROWS));
        if (got_q.size() == ROWS) begin
            chk("stream_sum0",  64'(got_q[0].sum),   64'd240);
            chk("stream_sum1",  64'(got_q[1].sum),   64'd752);
            chk("stream_idx1",  64'(got_q[1].index), 64'd1);
            chk("stream_last14", 64'(got_q[14].last), 64'd0);
            chk("stream_last15", 64'(got_q[15].last), 64'd1);
        end

        // Backpressure: three rows of 2s with downstream stalled.
        do_reset();
        for (int j = 0; j < 3 * DIM - 1; j++) feed_elem(32'd2, 1'b0);
        step(1'b1, 32'd2, 1'b0);
        chk("bp_stalled", 64'(accepted_now), 64'd0);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        feed_elem(32'd2, 1'b1);
        drain();
        chk("bp_rows", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk("bp_sum",   64'(got_q[j].sum),   64'd32);
                chk("bp_index", 64'(got_q[j].index), 64'(j));
            end
        end

        // Reset mid-row with a completed row still buffered.
        do_reset();
        for (int j = 0; j < DIM; j++) feed_elem(32'd4, 1'b0);
        for (int j = 0; j < 7; j++)   feed_elem(32'd6, 1'b0);
        #3;
        do_reset();
        for (int j = 0; j < DIM; j++) feed_elem(32'd10, 1'b1);
        drain();
        chk("mrst_rows", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) begin
            chk("mrst_sum",   64'(got_q[0].sum),   64'd160);
            chk("mrst_index", 64'(got_q[0].index), 64'd0);
        end

        // Random bubbles on both sides, 64 rows of even data.
        do_reset();
        k = 0;
        n = 0;
        d = {$urandom(), 1'b0} ;
        while (k < 64 * DIM && n < 20000) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, d, ($urandom_range(0, 3) != 0));
            if (accepted_now) begin
                k++;
                d = DATA_W'({$urandom()}) & ~DATA_W'(1);
            end
            n++;
        end
        chk("rand_all_fed", 64'(k), 64'(64 * DIM));
        drain();
        chk("rand_rows", 64'(got_q.size()), 64'd64);
        if (got_q.size() == 64) begin
            chk("rand_wrap_last", 64'(got_q[15].last),  64'd1);
            chk("rand_wrap_idx",  64'(got_q[16].index), 64'd0);
            chk("rand_final_idx", 64'(got_q[63].index), 64'd15);
        end

        // Single odd element: err follows the build option and sticks.
        do_reset();
        step(1'b1, 32'd3, 1'b1);
        for (int j = 0; j < 5; j++) step(1'b1, 32'd8, 1'b1);
        chk("par_err_sticky", 64'(err), 64'(PAR));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
